// File: rtl/dbus_rr_arbiter.sv
// dbus_rr_arbiter: round-robin N-master arbiter for the byte-masked data bus with read-return routing; DBUS_ARB_LOCK_EN adds bus locking
module dbus_rr_arbiter #(
  parameter int N_MASTERS  = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_BYTES = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_MASTERS-1:0]           m_en,
  input  logic [N_MASTERS-1:0]           m_rdwr,
  input  logic [N_MASTERS*DATA_BYTES-1:0] m_mask,
  input  logic [N_MASTERS*ADDR_W-1:0]    m_addr,
  input  logic [N_MASTERS*8*DATA_BYTES-1:0] m_wr_data,
`ifdef DBUS_ARB_LOCK_EN
  input  logic [N_MASTERS-1:0]           m_lock,
`endif
  output logic [N_MASTERS-1:0]           m_gnt,
  output logic [N_MASTERS-1:0]           m_rvalid,
  output logic [8*DATA_BYTES-1:0]        m_rd_data,
  output logic                           s_en,
  output logic                           s_rdwr,
  output logic [DATA_BYTES-1:0]          s_mask,
  output logic [ADDR_W-1:0]              s_addr,
  output logic [8*DATA_BYTES-1:0]        s_wr_data,
  input  logic [8*DATA_BYTES-1:0]        s_rd_data
);
  localparam int DW = 8*DATA_BYTES;
  localparam int IW = N_MASTERS > 1 ? $clog2(N_MASTERS) : 1;
  logic [IW-1:0] ptr, win, ptr_nxt;
  logic [N_MASTERS-1:0] elig;
  logic any;
  logic vld [RD_LATENCY];
  logic [IW-1:0] rid [RD_LATENCY];
`ifdef DBUS_ARB_LOCK_EN
  logic locked;
  logic [IW-1:0] owner;
  assign elig = locked ? m_en & (N_MASTERS'(1) << owner) : m_en;
`else
  assign elig = m_en;
`endif
  // scan downward so the lowest offset from ptr is the one left standing
  always_comb begin
    int idx;
    idx = 0;
    win = '0;
    any = 1'b0;
    for (int k = N_MASTERS-1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_MASTERS) idx -= N_MASTERS;
      if (elig[idx]) begin
        win = IW'(idx);
        any = 1'b1;
      end
    end
  end
  assign ptr_nxt   = (int'(win) == N_MASTERS-1) ? '0 : win + 1'b1;
  assign s_en      = any & ~rst;
  assign m_gnt     = s_en ? N_MASTERS'(1) << win : '0;
  assign s_rdwr    = s_en & m_rdwr[win];
  assign s_mask    = s_en ? m_mask[win*DATA_BYTES +: DATA_BYTES] : '0;
  assign s_addr    = s_en ? m_addr[win*ADDR_W +: ADDR_W] : '0;
  assign s_wr_data = s_en ? m_wr_data[win*DW +: DW] : '0;
  assign m_rd_data = s_rd_data;
  assign m_rvalid  = (vld[RD_LATENCY-1] & ~rst) ? N_MASTERS'(1) << rid[RD_LATENCY-1] : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        vld[i] <= 1'b0;
        rid[i] <= '0;
      end
    end else begin
      vld[0] <= s_en & ~s_rdwr;
      rid[0] <= win;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld[i] <= vld[i-1];
        rid[i] <= rid[i-1];
      end
`ifdef DBUS_ARB_LOCK_EN
      if (any && !locked) ptr <= ptr_nxt;
      if (any && locked && !m_lock[win]) ptr <= ptr_nxt;
`else
      if (any) ptr <= ptr_nxt;
`endif
    end
  end
`ifdef DBUS_ARB_LOCK_EN
  // owner keeps the bus until it completes a transfer with lock dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      locked <= 1'b0;
      owner  <= '0;
    end else if (any) begin
      locked <= m_lock[win];
      owner  <= win;
    end
  end
`endif
endmodule

// File: tb/tb_dbus_rr_arbiter.sv
// tb_dbus_rr_arbiter: directed checks of grant order, read routing, writes, reset and optional locking
module tb_dbus_rr_arbiter;
  localparam int N = 3, AW = 32, DB = 4, RL = 2, DW = 32;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] m_en = '0, m_rdwr = '0;
  logic [N*DB-1:0] m_mask = '0;
  logic [N*AW-1:0] m_addr = '0;
  logic [N*DW-1:0] m_wr_data = '0;
  logic [N-1:0] m_gnt, m_rvalid;
  logic [DW-1:0] m_rd_data, s_wr_data, s_rd_data, p1, p2;
  logic s_en, s_rdwr;
  logic [DB-1:0] s_mask;
  logic [AW-1:0] s_addr;
`ifdef DBUS_ARB_LOCK_EN
  logic [N-1:0] m_lock = '0;
`endif
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction
  always @(posedge clk) begin
    p1 <= mem(s_addr);
    p2 <= p1;
  end
  assign s_rd_data = p2;
  dbus_rr_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_BYTES(DB), .RD_LATENCY(RL)) dut (
    .clk(clk), .rst(rst), .m_en(m_en), .m_rdwr(m_rdwr), .m_mask(m_mask), .m_addr(m_addr),
    .m_wr_data(m_wr_data),
`ifdef DBUS_ARB_LOCK_EN
    .m_lock(m_lock),
`endif
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rd_data(m_rd_data), .s_en(s_en), .s_rdwr(s_rdwr),
    .s_mask(s_mask), .s_addr(s_addr), .s_wr_data(s_wr_data), .s_rd_data(s_rd_data));
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    m_en = 3'b111;
    m_addr = {32'h300, 32'h200, 32'h100};
    cyc();
    cyc();
    tests++; if (m_gnt !== 3'b000) begin fails++; $display("FAIL reset_gnt got %b exp 000", m_gnt); end
    tests++; if (s_en !== 1'b0) begin fails++; $display("FAIL reset_s_en got %b exp 0", s_en); end
    tests++; if (m_rvalid !== 3'b000) begin fails++; $display("FAIL reset_rvalid got %b exp 000", m_rvalid); end
    rst = 1'b0;
    #1;
    tests++; if (m_gnt !== 3'b001) begin fails++; $display("FAIL release_gnt got %b exp 001", m_gnt); end
  endtask
  task automatic test_fairness;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) cyc();
      tests++; if (m_gnt !== 3'(3'b001 << (k % 3))) begin fails++; $display("FAIL fair_gnt[%0d] got %b exp %b", k, m_gnt, 3'(3'b001 << (k % 3))); end
      tests++; if (s_addr !== 32'(32'h100 * (k % 3 + 1))) begin fails++; $display("FAIL fair_addr[%0d] got %h exp %h", k, s_addr, 32'(32'h100 * (k % 3 + 1))); end
      if (k >= 2) begin
        tests++; if (m_rvalid !== 3'(3'b001 << ((k - 2) % 3))) begin fails++; $display("FAIL fair_rvalid[%0d] got %b exp %b", k, m_rvalid, 3'(3'b001 << ((k - 2) % 3))); end
        tests++; if (m_rd_data !== mem(32'(32'h100 * ((k - 2) % 3 + 1)))) begin fails++; $display("FAIL fair_rdata[%0d] got %h exp %h", k, m_rd_data, mem(32'(32'h100 * ((k - 2) % 3 + 1)))); end
      end
    end
    cyc();
    m_en = '0;
    cyc();
    cyc();
    cyc();
    tests++; if (s_en !== 1'b0 || s_addr !== '0 || s_mask !== '0 || s_wr_data !== '0) begin fails++; $display("FAIL idle_fields got en=%b a=%h m=%b d=%h exp zeros", s_en, s_addr, s_mask, s_wr_data); end
    tests++; if (m_rvalid !== 3'b000) begin fails++; $display("FAIL idle_rvalid got %b exp 000", m_rvalid); end
  endtask
  task automatic test_read_routing;
    m_addr[AW +: AW] = 32'h10;
    m_en = 3'b010;
    #1;
    tests++; if (m_gnt !== 3'b010) begin fails++; $display("FAIL rd_gnt1 got %b exp 010", m_gnt); end
    cyc();
    m_addr[0 +: AW] = 32'h20;
    m_en = 3'b001;
    #1;
    tests++; if (m_gnt !== 3'b001 || s_addr !== 32'h20) begin fails++; $display("FAIL rd_gnt0 got %b/%h exp 001/00000020", m_gnt, s_addr); end
    tests++; if (m_rvalid !== 3'b000) begin fails++; $display("FAIL rd_early got %b exp 000", m_rvalid); end
    cyc();
    m_en = '0;
    #1;
    tests++; if (m_rvalid !== 3'b010 || m_rd_data !== mem(32'h10)) begin fails++; $display("FAIL rd_ret1 got %b/%h exp 010/%h", m_rvalid, m_rd_data, mem(32'h10)); end
    cyc();
    tests++; if (m_rvalid !== 3'b001 || m_rd_data !== mem(32'h20)) begin fails++; $display("FAIL rd_ret0 got %b/%h exp 001/%h", m_rvalid, m_rd_data, mem(32'h20)); end
    cyc();
    tests++; if (m_rvalid !== 3'b000) begin fails++; $display("FAIL rd_after got %b exp 000", m_rvalid); end
  endtask
  task automatic test_write;
    m_en = 3'b001;
    m_rdwr = 3'b001;
    m_mask[0 +: DB] = 4'b0011;
    m_wr_data[0 +: DW] = 32'hAABBCCDD;
    #1;
    tests++; if (m_gnt !== 3'b001 || s_rdwr !== 1'b1) begin fails++; $display("FAIL wr_gnt got %b rdwr=%b exp 001 rdwr=1", m_gnt, s_rdwr); end
    tests++; if (s_mask !== 4'b0011) begin fails++; $display("FAIL wr_mask got %b exp 0011", s_mask); end
    tests++; if (s_wr_data !== 32'hAABBCCDD) begin fails++; $display("FAIL wr_data got %h exp aabbccdd", s_wr_data); end
    cyc();
    m_en = '0;
    m_rdwr = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (m_rvalid !== 3'b000) begin fails++; $display("FAIL wr_rvalid[%0d] got %b exp 000", i, m_rvalid); end
      cyc();
    end
  endtask
  task automatic test_midflight_reset;
    m_en = 3'b001;
    cyc();
    rst = 1'b1;
    m_en = '0;
    #1;
    tests++; if (m_rvalid !== 3'b000) begin fails++; $display("FAIL mid_rst_rvalid got %b exp 000", m_rvalid); end
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if (m_rvalid !== 3'b000) begin fails++; $display("FAIL mid_after[%0d] got %b exp 000", i, m_rvalid); end
      cyc();
    end
  endtask
  task automatic test_wrap;
    m_en = 3'b110;
    #1;
    tests++; if (m_gnt !== 3'b010) begin fails++; $display("FAIL wrap_a got %b exp 010", m_gnt); end
    cyc();
    m_en = 3'b101;
    #1;
    tests++; if (m_gnt !== 3'b100) begin fails++; $display("FAIL wrap_b got %b exp 100", m_gnt); end
    cyc();
    #1;
    tests++; if (m_gnt !== 3'b001) begin fails++; $display("FAIL wrap_c got %b exp 001", m_gnt); end
    cyc();
    m_en = 3'b011;
    #1;
    tests++; if (m_gnt !== 3'b010) begin fails++; $display("FAIL wrap_d got %b exp 010", m_gnt); end
    cyc();
    m_en = '0;
    cyc();
    cyc();
    cyc();
  endtask
`ifdef DBUS_ARB_LOCK_EN
  task automatic test_lock;
    m_en = 3'b010;
    m_lock = 3'b010;
    #1;
    tests++; if (m_gnt !== 3'b010) begin fails++; $display("FAIL lock_take got %b exp 010", m_gnt); end
    cyc();
    m_en = 3'b011;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (m_gnt !== 3'b010) begin fails++; $display("FAIL lock_hold[%0d] got %b exp 010", i, m_gnt); end
      cyc();
    end
    m_en = 3'b001;
    #1;
    tests++; if (m_gnt !== 3'b000) begin fails++; $display("FAIL lock_block got %b exp 000", m_gnt); end
    cyc();
    m_en = 3'b011;
    m_lock = '0;
    #1;
    tests++; if (m_gnt !== 3'b010) begin fails++; $display("FAIL lock_release got %b exp 010", m_gnt); end
    cyc();
    #1;
    tests++; if (m_gnt !== 3'b001) begin fails++; $display("FAIL lock_after got %b exp 001", m_gnt); end
    cyc();
    m_en = '0;
    cyc();
    cyc();
  endtask
`endif
  initial begin
    test_reset();
    test_fairness();
    test_read_routing();
    test_write();
    test_midflight_reset();
    test_wrap();
`ifdef DBUS_ARB_LOCK_EN
    test_lock();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
